// File: rtl/pulse_toggle_bridge_pkg.sv
// Shared definitions for the multi-channel pulse/toggle bridge: mode
// encodings and the legal parameter ranges.
package pulse_toggle_bridge_pkg;

  localparam logic MODE_P2T = 1'b0;
  localparam logic MODE_T2P = 1'b1;

  localparam int N_MIN     = 1;
  localparam int N_MAX     = 32;
  localparam int SYNC_MIN  = 0;
  localparam int SYNC_MAX  = 3;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/pulse_toggle_bridge_channel.sv
// One bridge channel: optional input synchroniser, P2T/T2P event detection,
// registered output, saturating event counter and sticky overflow flag.
module ptb_channel
  import pulse_toggle_bridge_pkg::*;
#(
  parameter int SYNC  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             in,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic s;

  if (SYNC == 0) begin : g_no_sync
    assign s = in;
  end else begin : g_sync
    logic [SYNC-1:0] sync_q, sync_d;

    always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = in;
    end

    // Synchroniser stages are cleared by reset only, never by clr.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign s = sync_q[SYNC-1];
  end

  logic             mode_q, mode_d;
  logic             hist_q, hist_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             clear;
  logic             evt;

  // A mode change is treated exactly like an explicit clear for one cycle.
  assign clear = clr | (mode != mode_q);
  assign evt   = (mode_q == MODE_T2P) ? (s != hist_q) : s;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    mode_d  = mode;
    hist_d  = s;
    out_d   = out_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      out_d   = 1'b0;
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (mode_q == MODE_T2P) out_d = evt;
      else if (evt)           out_d = ~out_q;
      if (evt) begin
        if (&count_q) sat_d   = 1'b1;
        else          count_d = count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_P2T;
      hist_q  <= 1'b0;
      out_q   <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      hist_q  <= hist_d;
      out_q   <= out_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign out   = out_q;
  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/pulse_toggle_bridge.sv
// N independent pulse-to-toggle / toggle-to-pulse channels with per-channel
// saturating event counters packed into one count bus.
module pulse_toggle_bridge
  import pulse_toggle_bridge_pkg::*;
#(
  parameter int N     = 4,
  parameter int SYNC  = 2,
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       mode,
  input  logic [N-1:0]       in,
  input  logic [N-1:0]       clr,
  output logic [N-1:0]       out,
  output logic [N*CNT_W-1:0] count,
  output logic [N-1:0]       sat
);

  if (N < N_MIN || N > N_MAX || SYNC < SYNC_MIN || SYNC > SYNC_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_params
    $error("pulse_toggle_bridge: parameter out of range");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    ptb_channel #(
      .SYNC  (SYNC),
      .CNT_W (CNT_W)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .mode  (mode[i]),
      .in    (in[i]),
      .clr   (clr[i]),
      .out   (out[i]),
      .count (count[i*CNT_W +: CNT_W]),
      .sat   (sat[i])
    );
  end

endmodule

// File: tb/tb_pulse_toggle_bridge.sv
// Directed bench for pulse_toggle_bridge: three instances cover SYNC=2,
// SYNC=0 and a 2-bit counter for saturation.
module tb_pulse_toggle_bridge;

  logic clock = 1'b0;
  logic reset;

  logic [3:0]  mode_s, in_s, clr_s, out_s, sat_s;
  logic [31:0] count_s;
  logic [3:0]  mode_z, in_z, clr_z, out_z, sat_z;
  logic [31:0] count_z;
  logic [3:0]  mode_c, in_c, clr_c, out_c, sat_c;
  logic [7:0]  count_c;

  int n_total = 0;
  int n_bad   = 0;

  pulse_toggle_bridge #(.N(4), .SYNC(2), .CNT_W(8)) dut_s (
    .clock (clock), .reset (reset), .mode (mode_s), .in (in_s), .clr (clr_s),
    .out (out_s), .count (count_s), .sat (sat_s)
  );

  pulse_toggle_bridge #(.N(4), .SYNC(0), .CNT_W(8)) dut_z (
    .clock (clock), .reset (reset), .mode (mode_z), .in (in_z), .clr (clr_z),
    .out (out_z), .count (count_z), .sat (sat_z)
  );

  pulse_toggle_bridge #(.N(4), .SYNC(0), .CNT_W(2)) dut_c (
    .clock (clock), .reset (reset), .mode (mode_c), .in (in_c), .clr (clr_c),
    .out (out_c), .count (count_c), .sat (sat_c)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    mode_s = '0; clr_s = '0; in_s = '0;
    mode_z = '0; clr_z = '0; in_z = '0;
    mode_c = '0; clr_c = '0; in_c = '0;

    // Reset held with random activity on the inputs.
    for (int k = 0; k < 4; k++) begin
      in_s = 4'($urandom); in_z = 4'($urandom); in_c = 4'($urandom);
      tick();
    end
    check("rst_out",   {out_s, out_z, out_c}, 32'h0);
    check("rst_count_s", count_s, 32'h0);
    check("rst_count_z", count_z, 32'h0);
    check("rst_count_c", {24'h0, count_c}, 32'h0);
    check("rst_sat",   {sat_s, sat_z, sat_c}, 32'h0);
    in_s = '0; in_z = '0; in_c = '0;
    tick();
    reset = 1'b1;
    tick(4);

    // P2T through a 2-stage synchroniser: 1-cycle pulse, then 3 high cycles.
    in_s[0] = 1'b1;
    tick();
    check("p2t_sync_e1", out_s[0], 1'b0);
    in_s[0] = 1'b0;
    tick();
    check("p2t_sync_e2", out_s[0], 1'b0);
    tick();
    check("p2t_sync_e3", out_s[0], 1'b1);
    check("p2t_sync_cnt1", count_s[7:0], 8'd1);
    in_s[0] = 1'b1;
    tick(3);
    in_s[0] = 1'b0;
    tick(4);
    check("p2t_sync_end", out_s[0], 1'b0);
    check("p2t_sync_cnt4", count_s[7:0], 8'd4);

    // T2P, no synchroniser: mode switch first, then a rise and a fall.
    mode_z[1] = 1'b1;
    tick();
    check("t2p_modeclr", out_z[1], 1'b0);
    in_z[1] = 1'b1;
    tick();
    check("t2p_rise", out_z[1], 1'b1);
    check("t2p_cnt1", count_z[15:8], 8'd1);
    tick();
    check("t2p_rise_one", out_z[1], 1'b0);
    tick(4);
    check("t2p_hold", out_z[1], 1'b0);
    in_z[1] = 1'b0;
    tick();
    check("t2p_fall", out_z[1], 1'b1);
    tick();
    check("t2p_fall_one", out_z[1], 1'b0);
    check("t2p_cnt2", count_z[15:8], 8'd2);

    // Saturation with a 2-bit counter: five consecutive P2T events.
    in_c[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("sat_cnt_%0d", k), {30'h0, count_c[1:0]}, (k < 3) ? k : 3);
      check($sformatf("sat_flag_%0d", k), sat_c[0], (k >= 4) ? 1 : 0);
      check($sformatf("sat_out_%0d", k), out_c[0], k % 2);
    end
    in_c[0] = 1'b0;
    clr_c[0] = 1'b1;
    tick();
    clr_c[0] = 1'b0;
    check("sat_clr_cnt", {30'h0, count_c[1:0]}, 32'd0);
    check("sat_clr_flag", sat_c[0], 1'b0);
    check("sat_clr_out", out_c[0], 1'b0);

    // Clear colliding with a P2T event, then with a T2P transition.
    in_z[2] = 1'b1; clr_z[2] = 1'b1;
    tick();
    check("col_p2t_out", out_z[2], 1'b0);
    check("col_p2t_cnt", count_z[23:16], 8'd0);
    in_z[2] = 1'b0; clr_z[2] = 1'b0;
    mode_z[2] = 1'b1;
    tick();
    in_z[2] = 1'b1; clr_z[2] = 1'b1;
    tick();
    check("col_t2p_out", out_z[2], 1'b0);
    clr_z[2] = 1'b0;
    tick();
    check("col_t2p_after", out_z[2], 1'b0);
    check("col_t2p_cnt", count_z[23:16], 8'd0);

    // Mode switch on channel 3 with out=1 and count=5.
    for (int k = 0; k < 5; k++) begin
      in_z[3] = 1'b1;
      tick();
      in_z[3] = 1'b0;
      tick();
    end
    check("msw_pre_out", out_z[3], 1'b1);
    check("msw_pre_cnt", count_z[31:24], 8'd5);
    in_z[3] = 1'b1; mode_z[3] = 1'b1;
    tick();
    check("msw_clr_out", out_z[3], 1'b0);
    check("msw_clr_cnt", count_z[31:24], 8'd0);
    tick();
    check("msw_no_pulse", out_z[3], 1'b0);
    in_z[3] = 1'b0;
    tick();
    check("msw_pulse", out_z[3], 1'b1);
    check("msw_pulse_cnt", count_z[31:24], 8'd1);
    tick();
    check("msw_pulse_end", out_z[3], 1'b0);

    // Independence: other channel counts on dut_z unaffected.
    check("indep_ch0_cnt", count_z[7:0], 8'd0);

    // Asynchronous reset mid-cycle while out=1.
    in_z[0] = 1'b1;
    tick();
    in_z[0] = 1'b0;
    check("arst_pre_out", out_z[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_out", out_z[0], 1'b0);
    check("arst_cnt", count_z[7:0], 8'd0);
    mode_z = '0;
    tick();
    reset = 1'b1;
    tick();
    in_z[0] = 1'b1;
    tick();
    in_z[0] = 1'b0;
    check("arst_post_out", out_z[0], 1'b1);
    check("arst_post_cnt", count_z[7:0], 8'd1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
